// File: rtl/mem_stage_if.sv
// Data-bus request/acknowledge interface between the memory stage and the bus.
//   dbus_req   : request, held until dbus_ack is sampled high
//   dbus_we    : 1 = write, 0 = read
//   dbus_addr  : word-aligned byte address
//   dbus_be    : byte enables
//   dbus_wdata : write data
//   dbus_ack   : completion, meaningful only while dbus_req = 1
//   dbus_rdata : read data, valid with dbus_ack on reads
interface mem_stage_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: forwards ALU results to write-back, runs
// loads/stores over the data bus, and holds one op arriving while busy.
//   clk, rst_n      : clock, synchronous active-low reset
//   EX_*            : registered execute-stage outputs (ALU result or load/store)
//   mem_busy        : stall to upstream (combinational from state)
//   dbus            : data-bus master port (mem_stage_if.master)
//   WB_*            : register write-back, WB_x_rd_vld is a one-cycle pulse
//   mem_err         : one-cycle pulse on misaligned/conflicting/timed-out/overflowed op
module mem_stage #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_x_rd_vld,
    input  logic [31:0] EX_x_rd,
    input  logic [4:0]  EX_rd_idx,
    input  logic [31:0] EX_MEMaddr,
    input  logic [3:0]  EX_MEMrden,
    input  logic [3:0]  EX_MEMwren,
    input  logic [31:0] EX_MEMwrdata,
    output logic        mem_busy,
    mem_stage_if.master dbus,
    output logic        WB_x_rd_vld,
    output logic [31:0] WB_x_rd,
    output logic [4:0]  WB_rd_idx,
    output logic        mem_err
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RIDX_W = 5;
    localparam int unsigned BE_W   = 4;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef struct packed {
        logic              alu_vld;
        logic [XLEN-1:0]   alu_data;
        logic [RIDX_W-1:0] rd_idx;
        logic [XLEN-1:0]   addr;
        logic [BE_W-1:0]   rden;
        logic [BE_W-1:0]   wren;
        logic [XLEN-1:0]   wdata;
    } op_t;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t            state_q, state_nxt;
    op_t               hold_q, hold_nxt;
    logic              hold_vld_q, hold_vld_nxt;
    logic [TO_W-1:0]   cnt_q, cnt_nxt;
    logic [RIDX_W-1:0] ld_idx_q, ld_idx_nxt;

    logic              req_q, req_nxt;
    logic              we_q, we_nxt;
    logic [XLEN-1:0]   addr_q, addr_nxt;
    logic [BE_W-1:0]   be_q, be_nxt;
    logic [XLEN-1:0]   wdata_q, wdata_nxt;
    logic              wb_vld_q, wb_vld_nxt;
    logic [XLEN-1:0]   wb_data_q, wb_data_nxt;
    logic [RIDX_W-1:0] wb_idx_q, wb_idx_nxt;
    logic              err_q, err_nxt;

    op_t               in_op, cur_op;
    logic              in_vld;
    logic              cur_ld, cur_st, cur_bad;
    logic [BE_W-1:0]   cur_be;
    logic              issue, done, go_req;

    // Incoming op, and the op to process this cycle (held op while draining)
    assign in_op  = '{EX_x_rd_vld, EX_x_rd, EX_rd_idx, EX_MEMaddr,
                      EX_MEMrden, EX_MEMwren, EX_MEMwrdata};
    assign in_vld = in_op.alu_vld | (|in_op.rden) | (|in_op.wren);
    assign cur_op = (state_q == DRAIN) ? hold_q : in_op;
    assign cur_ld = |cur_op.rden;
    assign cur_st = |cur_op.wren;
    assign cur_be = cur_st ? cur_op.wren : cur_op.rden;
    // Full-word access must be word aligned; load and store together is illegal
    assign cur_bad = (cur_ld & cur_st) |
                     ((cur_be == 4'hF) && (cur_op.addr[1:0] != 2'b00));

    assign mem_busy         = (state_q != IDLE) | hold_vld_q;
    assign dbus.dbus_req    = req_q;
    assign dbus.dbus_we     = we_q;
    assign dbus.dbus_addr   = addr_q;
    assign dbus.dbus_be     = be_q;
    assign dbus.dbus_wdata  = wdata_q;
    assign WB_x_rd_vld      = wb_vld_q;
    assign WB_x_rd          = wb_data_q;
    assign WB_rd_idx        = wb_idx_q;
    assign mem_err          = err_q;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            cnt_q      <= '0;
            ld_idx_q   <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_vld_q   <= 1'b0;
            wb_data_q  <= '0;
            wb_idx_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            hold_q     <= hold_nxt;
            hold_vld_q <= hold_vld_nxt;
            cnt_q      <= cnt_nxt;
            ld_idx_q   <= ld_idx_nxt;
            req_q      <= req_nxt;
            we_q       <= we_nxt;
            addr_q     <= addr_nxt;
            be_q       <= be_nxt;
            wdata_q    <= wdata_nxt;
            wb_vld_q   <= wb_vld_nxt;
            wb_data_q  <= wb_data_nxt;
            wb_idx_q   <= wb_idx_nxt;
            err_q      <= err_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt    = state_q;
        hold_nxt     = hold_q;
        hold_vld_nxt = hold_vld_q;
        cnt_nxt      = cnt_q;
        ld_idx_nxt   = ld_idx_q;
        req_nxt      = req_q;
        we_nxt       = we_q;
        addr_nxt     = addr_q;
        be_nxt       = be_q;
        wdata_nxt    = wdata_q;
        wb_vld_nxt   = 1'b0;
        wb_data_nxt  = wb_data_q;
        wb_idx_nxt   = wb_idx_q;
        err_nxt      = 1'b0;
        issue        = 1'b0;
        done         = 1'b0;
        go_req       = 1'b0;

        case (state_q)
            IDLE: begin
                issue = in_vld;
            end
            REQ: begin
                // A second arrival while the buffer is full is dropped
                if (in_vld) begin
                    if (hold_vld_q) begin
                        err_nxt = 1'b1;
                    end else begin
                        hold_vld_nxt = 1'b1;
                        hold_nxt     = in_op;
                    end
                end
                // Ack takes priority over a coincident timeout
                if (dbus.dbus_ack) begin
                    req_nxt = 1'b0;
                    done    = 1'b1;
                    if (!we_q) begin
                        wb_vld_nxt  = 1'b1;
                        wb_data_nxt = dbus.dbus_rdata;
                        wb_idx_nxt  = ld_idx_q;
                    end
                end else if (cnt_q == TO_LAST) begin
                    req_nxt = 1'b0;
                    err_nxt = 1'b1;
                    done    = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + TO_W'(1);
                end
                if (done) begin
                    state_nxt = hold_vld_nxt ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                // Held op leaves; a new arrival may take its place
                issue        = 1'b1;
                hold_vld_nxt = 1'b0;
                if (in_vld) begin
                    hold_vld_nxt = 1'b1;
                    hold_nxt     = in_op;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Process cur_op as a fresh arrival
        if (issue) begin
            if (cur_ld | cur_st) begin
                if (cur_bad) begin
                    err_nxt = 1'b1;
                end else begin
                    go_req     = 1'b1;
                    req_nxt    = 1'b1;
                    we_nxt     = cur_st;
                    addr_nxt   = {cur_op.addr[XLEN-1:2], 2'b00};
                    be_nxt     = cur_be;
                    wdata_nxt  = cur_op.wdata;
                    ld_idx_nxt = cur_op.rd_idx;
                    cnt_nxt    = '0;
                end
            end else if (cur_op.alu_vld) begin
                wb_vld_nxt  = 1'b1;
                wb_data_nxt = cur_op.alu_data;
                wb_idx_nxt  = cur_op.rd_idx;
            end
            state_nxt = go_req ? REQ : (hold_vld_nxt ? DRAIN : IDLE);
        end
    end

endmodule
